ib_stream_packer: RTL and testbench
===================================

Name: ib_stream_packer

Overview:
Parametrised inbound ingest block on the H2C path, behind the DMA H2C AXI-stream and in front of the shared packet RAM.
- Packs AXIS_W-bit stream beats into RAM_W-bit RAM words.
- Places each packet in the next free per-channel slot, picked round-robin over NUM_CH crypto channels.
- Runs a per-slot FREE/FILL/FULL ownership handshake with the crypto engine.
- Generalises the fixed 8-channel, 64→128-bit inbound controller in channel count, widths and slot depth.
- Adds overflow truncation and round-robin slot selection.

Parameters:
NUM_CH, 8, number of channel slots (1..16)
AXIS_W, 64, stream data width; RAM_W must be an integer multiple of it (ratio R = RAM_W/AXIS_W, 1..4)
RAM_W, 128, RAM word width
SLOT_WORDS, 64, RAM words per slot (power of 2)
ADDR_W, 32, RAM word-address width
BASE_ADDR, 0, word address of slot 0

Ports:
clk  in  1  clock (axi_aclk domain)
rst_n  in  1  asynchronous active-low reset
s_tdata  in  AXIS_W  H2C stream data
s_tkeep  in  AXIS_W/8  byte enables
s_tvalid  in  1  stream valid
s_tready  out  1  stream ready
s_tlast  in  1  end of packet
wr_data  out  RAM_W  RAM write data
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W  RAM word address
data_valid  out  NUM_CH  slot i holds a complete packet (level)
ram_valid  in  NUM_CH  crypto releases slot i (1-cycle pulse)
err_ovf  out  1  1-cycle pulse: packet truncated

Behaviour:
Reset values:
- All outputs are 0.
- All slots are FREE.
- Round-robin pointer is 0.
- FSM is in IDLE.
- Reset may assert mid-packet; the partial packet is discarded and no write completes after reset.

Slot state per channel:
- FREE → FILL when the slot is selected.
- FILL → FULL on the cycle the final word of the packet is written.
- FULL → FREE on a ram_valid[i] pulse.
- data_valid[i] = (state==FULL), registered.
- ram_valid[i] while not FULL is ignored.

Slot selection:
- Candidates are FREE slots, searched from the RR pointer upward with wrap.
- After a selection, the pointer moves to the selected slot + 1 mod NUM_CH.
- A ram_valid arriving in the same cycle as a search is visible to the search one cycle later.

FSM:
- IDLE: s_tready=0. If any slot is FREE, latch it as cur_ch, clear word_idx and lane count, go to RECV (1 cycle). If none is FREE, stay in IDLE.
- RECV:
  - s_tready=1.
  - Each accepted beat is placed into lane (lane count) of the pack register, lane 0 at the LSBs.
  - Bytes with tkeep=0 are written as 0x00.
  - When lane count reaches R-1 or tlast is accepted, the word is issued: wr_en=1 the next cycle, wr_addr = BASE_ADDR + cur_ch*SLOT_WORDS + word_idx. Unfilled lanes are zero. word_idx then increments.
  - On tlast: the slot goes FULL in the same cycle as the final write, and the FSM returns to IDLE.
- DROP:
  - Entered when a word would be issued with word_idx == SLOT_WORDS (slot full) and the packet has not ended.
  - That word is not written. err_ovf pulses once.
  - s_tready=1; beats are discarded until tlast.
  - On tlast: slot goes FULL, FSM returns to IDLE.
  - An exact-fit packet (final word at word_idx SLOT_WORDS-1, carrying tlast) does not raise err_ovf.

Handshake and timing:
- A beat transfers only when s_tvalid & s_tready.
- Back-to-back beats are accepted at 1 per cycle.
- There is one bubble cycle per packet (the IDLE cycle).
- Write latency is 1 cycle from the completing beat to wr_en.

Optional Feature:
IB_LEN_HDR_EN
- When defined:
  - Word 0 of each slot is reserved for a header; payload starts at word 1, giving capacity SLOT_WORDS-1.
  - On packet end (tlast accepted, normal or DROP), one extra write is issued to word 0, the cycle after the final payload write.
  - Header contents: [15:0] = accepted byte count (sum of tkeep ones, saturating at 0xFFFF, counting only bytes actually written); [16] = truncated flag; remaining bits 0.
  - The slot goes FULL with the header write, not with the final payload write.
- When not defined: no header, payload starts at word 0, and no byte counter is built.

Test Plan:
1. Reset, then a 4-beat packet (tkeep=0xFF) → 2 writes to addr BASE+0 and BASE+1; data_valid=0x01 in the cycle after the 2nd wr_en; RR pointer=1.
2. 3-beat packet, last tkeep=0x0F → 2nd write has upper 64 bits zero and bytes [63:32] of the lower lane zero; with IB_LEN_HDR_EN, header byte count = 20.
3. NUM_CH packets sent with no ram_valid → slots 0..7 FULL, data_valid=0xFF; 9th packet sees s_tready held 0. Pulse ram_valid[3] → 9th packet lands in slot 3 at addr BASE+3*64.
4. Packet of 2*SLOT_WORDS+4 beats → exactly SLOT_WORDS writes, one err_ovf pulse, s_tready stays 1 until tlast, slot ends FULL. Exact-fit 128-beat packet → no err_ovf.
5. rst_n low mid-packet at beat 5 → wr_en, s_tready, data_valid are 0 immediately (asynchronous); the next packet goes to slot 0 at word 0.
6. ram_valid[2] pulsed while slot 2 is FREE or FILL → ignored; state and data_valid unchanged.

Source files
------------

// File: rtl/ib_stream_packer_if.sv
// H2C AXI-stream beat channel feeding the inbound packer.
interface ib_stream_packer_if #(
    parameter int AXIS_W = 64
);
    logic [AXIS_W-1:0]   s_tdata;
    logic [AXIS_W/8-1:0] s_tkeep;
    logic                s_tvalid;
    logic                s_tready;
    logic                s_tlast;

    modport master (output s_tdata, s_tkeep, s_tvalid, s_tlast, input s_tready);
    modport slave  (input s_tdata, s_tkeep, s_tvalid, s_tlast, output s_tready);
endinterface

// File: rtl/ib_stream_packer.sv
// Inbound H2C packer: AXIS beats -> RAM words, one packet per round-robin FREE slot, FREE/FILL/FULL handoff.
// Define IB_LEN_HDR_EN to reserve word 0 of each slot for a {truncated, byte count} header.
module ib_stream_packer #(
    parameter int                NUM_CH     = 8,
    parameter int                AXIS_W     = 64,
    parameter int                RAM_W      = 128,
    parameter int                SLOT_WORDS = 64,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    ib_stream_packer_if.slave axis,
    output logic [RAM_W-1:0]  wr_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [NUM_CH-1:0] data_valid,
    input  logic [NUM_CH-1:0] ram_valid,
    output logic              err_ovf
);
    localparam int R  = RAM_W / AXIS_W;
    localparam int KW = AXIS_W / 8;
    localparam int LW = (R > 1) ? $clog2(R) : 1;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IW = $clog2(SLOT_WORDS) + 1;
`ifdef IB_LEN_HDR_EN
    localparam logic [IW-1:0] FIRST_IDX = IW'(1);
`else
    localparam logic [IW-1:0] FIRST_IDX = '0;
`endif

    typedef enum logic [1:0] {IDLE, RECV, DROP, HDR} state_t;
    state_t state_q, state_d;

    logic [NUM_CH-1:0] slot_busy, slot_full;   // busy covers FILL and FULL
    logic [CW-1:0]     rr_q, cur_ch, sel, c_idx;
    logic [IW-1:0]     word_idx;
    logic [LW-1:0]     lane;
    logic [RAM_W-1:0]  pack_q, word_nxt;
    logic [AXIS_W-1:0] beat_m;
    logic [ADDR_W-1:0] slot_base;
    logic              found, take, accept, issue, ovf, pkt_end;

    assign axis.s_tready = (state_q == RECV) || (state_q == DROP);
    assign accept        = axis.s_tvalid & axis.s_tready;
    assign issue         = accept && (state_q == RECV) && ((lane == LW'(R-1)) || axis.s_tlast);
    assign ovf           = issue && (word_idx == IW'(SLOT_WORDS));
    assign slot_base     = BASE_ADDR + (ADDR_W'(cur_ch) << $clog2(SLOT_WORDS));

    // First FREE slot at or after the round-robin pointer, with wrap
    always_comb begin
        found = 1'b0;
        sel   = '0;
        c_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            c_idx = CW'((int'(rr_q) + k) % NUM_CH);
            if (!found && !slot_busy[c_idx]) begin
                found = 1'b1;
                sel   = c_idx;
            end
        end
    end

    always_comb begin
        beat_m = '0;
        for (int b = 0; b < KW; b++)
            if (axis.s_tkeep[b]) beat_m[b*8 +: 8] = axis.s_tdata[b*8 +: 8];
    end

    // Lanes above the current one are still zero in pack_q, so a short final word is zero-filled
    always_comb begin
        word_nxt = pack_q;
        word_nxt[lane*AXIS_W +: AXIS_W] = beat_m;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        pkt_end = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                take    = 1'b1;
                state_d = RECV;
            end
            RECV, DROP: begin
                if (accept && axis.s_tlast) begin
`ifdef IB_LEN_HDR_EN
                    state_d = HDR;
`else
                    state_d = IDLE;
                    pkt_end = 1'b1;
`endif
                end else if (ovf) begin
                    state_d = DROP;
                end
            end
            HDR: begin
                state_d = IDLE;
                pkt_end = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_busy[i] <= 1'b0;
                slot_full[i] <= 1'b0;
            end else if (take && sel == CW'(i)) begin
                slot_busy[i] <= 1'b1;
            end else if (pkt_end && cur_ch == CW'(i)) begin
                slot_full[i] <= 1'b1;
            end else if (slot_full[i] && ram_valid[i]) begin
                slot_busy[i] <= 1'b0;
                slot_full[i] <= 1'b0;
            end
        end
    end

`ifdef IB_LEN_HDR_EN
    logic [15:0] byte_cnt, pend_cnt, beat_cnt;
    logic [16:0] cnt_sum;
    logic        trunc;

    // Bytes only count once their word is actually written
    assign beat_cnt = 16'($countones(axis.s_tkeep));
    assign cnt_sum  = {1'b0, byte_cnt} + {1'b0, pend_cnt} + {1'b0, beat_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            pend_cnt <= '0;
            trunc    <= 1'b0;
        end else if (take) begin
            byte_cnt <= '0;
            pend_cnt <= '0;
            trunc    <= 1'b0;
        end else if (issue) begin
            pend_cnt <= '0;
            if (ovf) trunc    <= 1'b1;
            else     byte_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end else if (accept && state_q == RECV) begin
            pend_cnt <= pend_cnt + beat_cnt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            cur_ch     <= '0;
            word_idx   <= '0;
            lane       <= '0;
            pack_q     <= '0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            wr_addr    <= '0;
            err_ovf    <= 1'b0;
            data_valid <= '0;
        end else begin
            wr_en      <= 1'b0;
            err_ovf    <= 1'b0;
            data_valid <= slot_full;
            if (take) begin
                cur_ch   <= sel;
                rr_q     <= (sel == CW'(NUM_CH-1)) ? '0 : sel + 1'b1;
                word_idx <= FIRST_IDX;
                lane     <= '0;
                pack_q   <= '0;
            end
            if (issue) begin
                pack_q <= '0;
                lane   <= '0;
                if (ovf) begin
                    err_ovf <= 1'b1;
                end else begin
                    wr_en    <= 1'b1;
                    wr_data  <= word_nxt;
                    wr_addr  <= slot_base + ADDR_W'(word_idx);
                    word_idx <= word_idx + 1'b1;
                end
            end else if (accept && state_q == RECV) begin
                pack_q <= word_nxt;
                lane   <= lane + 1'b1;
            end
`ifdef IB_LEN_HDR_EN
            if (state_q == HDR) begin
                wr_en   <= 1'b1;
                wr_addr <= slot_base;
                wr_data <= RAM_W'({trunc, byte_cnt});
            end
`endif
        end
    end
endmodule

// File: tb/tb_ib_stream_packer.sv
// Randomised bench for ib_stream_packer; expected RAM writes come from a packet-level model of slots and words.
`timescale 1ns/1ps
module tb_ib_stream_packer;
    localparam int NUM_CH = 8, AXIS_W = 64, RAM_W = 128, SLOT_WORDS = 64, ADDR_W = 32;
    localparam logic [ADDR_W-1:0] BASE = 32'h0000_1000;
    localparam int R  = RAM_W / AXIS_W;
    localparam int KW = AXIS_W / 8;
`ifdef IB_LEN_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int CAP = SLOT_WORDS - HDR;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic [RAM_W-1:0]  wr_data;
    logic              wr_en, err_ovf;
    logic [ADDR_W-1:0] wr_addr;
    logic [NUM_CH-1:0] data_valid, ram_valid;

    ib_stream_packer_if #(.AXIS_W(AXIS_W)) axis ();

    ib_stream_packer #(
        .NUM_CH(NUM_CH), .AXIS_W(AXIS_W), .RAM_W(RAM_W), .SLOT_WORDS(SLOT_WORDS),
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .axis(axis), .wr_data(wr_data), .wr_en(wr_en),
        .wr_addr(wr_addr), .data_valid(data_valid), .ram_valid(ram_valid), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [RAM_W-1:0] got, input logic [RAM_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write / error / data_valid monitor, sampled on the falling edge
    int cyc = 0, ovf_cnt = 0, dv_rise_cyc = -1, last_acc_cyc = 0;
    logic [ADDR_W-1:0] got_a[$];
    logic [RAM_W-1:0]  got_d[$];
    int                got_c[$];
    logic [NUM_CH-1:0] dv_prev = '0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            got_a.push_back(wr_addr);
            got_d.push_back(wr_data);
            got_c.push_back(cyc);
        end
        if (rst_n && err_ovf) ovf_cnt++;
        if ((data_valid & ~dv_prev) != '0 && dv_rise_cyc < 0) dv_rise_cyc = cyc;
        dv_prev = data_valid;
    end

    // Reference model: slot occupancy, RR pointer, and the write list implied by one packet
    logic [NUM_CH-1:0] full_m;
    int                rr_m;
    logic [AXIS_W-1:0] pd[$];
    logic [KW-1:0]     pk[$];
    logic [ADDR_W-1:0] exp_a[$];
    logic [RAM_W-1:0]  exp_d[$];
    logic              exp_ovf;

    function automatic int pick_slot();
        for (int k = 0; k < NUM_CH; k++) begin
            int c = (rr_m + k) % NUM_CH;
            if (!full_m[c]) return c;
        end
        return -1;
    endfunction

    task automatic gen_pkt(input int n, input logic [KW-1:0] last_keep, input bit rnd_keep);
        pd.delete();
        pk.delete();
        for (int i = 0; i < n; i++) begin
            pd.push_back({$urandom(), $urandom()});
            pk.push_back(rnd_keep ? KW'($urandom()) : {KW{1'b1}});
        end
        pk[n-1] = last_keep;
    endtask

    task automatic model_pkt(input int ch);
        int n, nw, bytes;
        logic [RAM_W-1:0] w;
        exp_a.delete();
        exp_d.delete();
        n     = pd.size();
        nw    = (n + R - 1) / R;
        bytes = 0;
        exp_ovf = (nw > CAP);
        for (int j = 0; j < nw && j < CAP; j++) begin
            w = '0;
            for (int l = 0; l < R; l++)
                if (j*R + l < n)
                    for (int b = 0; b < KW; b++)
                        if (pk[j*R+l][b]) begin
                            w[l*AXIS_W + b*8 +: 8] = pd[j*R+l][b*8 +: 8];
                            bytes++;
                        end
            exp_a.push_back(BASE + ADDR_W'(ch*SLOT_WORDS + HDR + j));
            exp_d.push_back(w);
        end
        if (HDR == 1) begin
            w = '0;
            w[15:0] = (bytes > 65535) ? 16'hFFFF : 16'(bytes);
            w[16]   = exp_ovf;
            exp_a.push_back(BASE + ADDR_W'(ch*SLOT_WORDS));
            exp_d.push_back(w);
        end
    endtask

    task automatic send_pkt(input int gaps, input logic [NUM_CH-1:0] rv_mask, input int rv_beat,
                            input int stop_at, output int stalls);
        int budget;
        stalls = 0;
        for (int i = 0; i < pd.size(); i++) begin
            if (i == stop_at) return;
            @(negedge clk);
            ram_valid = '0;
            if (gaps != 0 && $urandom_range(0, 3) == 0) begin
                axis.s_tvalid = 1'b0;
                @(negedge clk);
            end
            axis.s_tdata  = pd[i];
            axis.s_tkeep  = pk[i];
            axis.s_tlast  = (i == pd.size() - 1);
            axis.s_tvalid = 1'b1;
            if (i == rv_beat) ram_valid = rv_mask;
            budget = 0;
            while (axis.s_tready !== 1'b1 && budget < 300) begin
                if (i > 0) stalls++;
                @(negedge clk);
                ram_valid = '0;
                budget++;
            end
            if (budget >= 300) begin
                chk("tready_timeout", axis.s_tready, 1);
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $fatal(1, "stream stalled");
            end
            if (i == pd.size() - 1) last_acc_cyc = cyc;
            @(posedge clk);
        end
        @(negedge clk);
        axis.s_tvalid = 1'b0;
        axis.s_tlast  = 1'b0;
        ram_valid     = '0;
    endtask

    task automatic run_pkt(input string tag, input int gaps, input logic [NUM_CH-1:0] rv_mask,
                           input int rv_beat, output int stalls);
        int ch, t;
        ch = pick_slot();
        model_pkt(ch);
        got_a.delete();
        got_d.delete();
        got_c.delete();
        ovf_cnt = 0;
        send_pkt(gaps, rv_mask, rv_beat, -1, stalls);
        t = 0;
        while (got_a.size() < exp_a.size() && t < 40) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_nwr"}, got_a.size(), exp_a.size());
        for (int j = 0; j < exp_a.size() && j < got_a.size(); j++) begin
            chk({tag, "_addr"}, got_a[j], exp_a[j]);
            chk({tag, "_data"}, got_d[j], exp_d[j]);
        end
        chk({tag, "_ovf"}, ovf_cnt, exp_ovf);
        if (rv_beat > 0 && rv_beat < pd.size()) full_m &= ~rv_mask;
        full_m[ch] = 1'b1;
        rr_m = (ch + 1) % NUM_CH;
        chk({tag, "_dv"}, data_valid, full_m);
    endtask

    initial begin
        int st, held, n;
        logic [NUM_CH-1:0] m;
        logic [RAM_W-1:0]  w;
        axis.s_tvalid = 1'b0;
        axis.s_tdata  = '0;
        axis.s_tkeep  = '0;
        axis.s_tlast  = 1'b0;
        ram_valid     = '0;
        full_m        = '0;
        rr_m          = 0;

        repeat (3) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_tready", axis.s_tready, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_ovf", err_ovf, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        rst_n = 1'b1;

        // Full-keep 4-beat packet into slot 0
        gen_pkt(4, {KW{1'b1}}, 1'b0);
        run_pkt("t1", 0, '0, 0, st);
        chk("t1_wr_lat", got_c[exp_a.size()-1-HDR], last_acc_cyc + 1);
        chk("t1_dv_time", dv_rise_cyc, got_c[got_c.size()-1] + 1);

        // Partial last beat -> zero-filled bytes/lane
        gen_pkt(3, 8'h0F, 1'b0);
        run_pkt("t2", 0, '0, 0, st);
        w = got_d[1];
        chk("t2_upper_zero", w[127:32], 0);

        // ram_valid on a FREE slot, then on the FILL slot, is ignored
        @(negedge clk);
        ram_valid = 8'h04;
        @(negedge clk);
        ram_valid = '0;
        repeat (2) @(negedge clk);
        chk("t6_free_dv", data_valid, full_m);
        gen_pkt(6, {KW{1'b1}}, 1'b0);
        run_pkt("t6_fill", 1, 8'h04, 1, st);

        // Fill every slot, then a further packet must wait for a release
        while (pick_slot() >= 0) begin
            gen_pkt($urandom_range(1, 6), KW'($urandom_range(1, 255)), 1'b1);
            run_pkt("t3_fill", 1, '0, 0, st);
        end
        chk("t3_dv_all", data_valid, {NUM_CH{1'b1}});
        gen_pkt(3, {KW{1'b1}}, 1'b0);
        @(negedge clk);
        axis.s_tdata  = pd[0];
        axis.s_tkeep  = pk[0];
        axis.s_tvalid = 1'b1;
        held = 0;
        repeat (10) begin
            @(negedge clk);
            held += int'(axis.s_tready);
        end
        chk("t3_hold", held, 0);
        ram_valid = 8'h08;
        @(negedge clk);
        ram_valid = '0;
        full_m[3] = 1'b0;
        run_pkt("t3_slot3", 0, '0, 0, st);
        chk("t3_addr", got_a[0], BASE + ADDR_W'(3*SLOT_WORDS + HDR));
        @(negedge clk);
        ram_valid = {NUM_CH{1'b1}};
        @(negedge clk);
        ram_valid = '0;
        full_m = '0;
        repeat (2) @(negedge clk);
        chk("rel_dv", data_valid, 0);

        // Overflow truncation, then exact fit
        gen_pkt(2*SLOT_WORDS + 4, {KW{1'b1}}, 1'b0);
        run_pkt("t4_ovf", 0, '0, 0, st);
        chk("t4_stall", st, 0);
        gen_pkt(CAP*R, {KW{1'b1}}, 1'b0);
        run_pkt("t4_exact", 0, '0, 0, st);

        // Random packets with random releases
        for (int p = 0; p < 40; p++) begin
            if (pick_slot() < 0) begin
                m = full_m & NUM_CH'($urandom());
                if (m == '0) m = full_m;
                @(negedge clk);
                ram_valid = m;
                @(negedge clk);
                ram_valid = '0;
                full_m &= ~m;
                @(negedge clk);
            end
            n = $urandom_range(1, 24);
            gen_pkt(n, KW'($urandom_range(1, 255)), bit'($urandom_range(0, 1)));
            run_pkt("rnd", 1, NUM_CH'($urandom()), $urandom_range(1, 24), st);
        end

        // Asynchronous reset in the middle of a packet
        if (pick_slot() < 0) begin
            @(negedge clk);
            ram_valid = 8'h01;
            @(negedge clk);
            ram_valid = '0;
            full_m[0] = 1'b0;
        end
        gen_pkt(10, {KW{1'b1}}, 1'b0);
        send_pkt(0, '0, 0, 4, st);
        #2;
        chk("t5_pre_wr_en", wr_en, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_wr_en", wr_en, 0);
        chk("t5_tready", axis.s_tready, 0);
        chk("t5_dv", data_valid, 0);
        axis.s_tvalid = 1'b0;
        axis.s_tlast  = 1'b0;
        full_m = '0;
        rr_m   = 0;
        repeat (2) @(negedge clk);
        got_a.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_no_write", got_a.size(), 0);
        gen_pkt(5, 8'h3C, 1'b0);
        run_pkt("t5_after", 0, '0, 0, st);
        chk("t5_addr", got_a[0], BASE + ADDR_W'(HDR));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
